// File: rtl/sort_net.sv
// sort_net: registered bitonic sorting network ordering lanes by {~valid, key}.
// A single enable (adv) freezes every stage; sideband, count and mode ride with each beat.
module sort_net #(
  parameter int LANES  = 8,
  parameter int DATA_W = 32,
  parameter int KEY_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES-1:0]        in_lane_valid,
  input  logic                    in_mode,
  input  logic                    in_last,
  input  logic [1:0]              in_ctrl,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [LANES-1:0]        out_lane_valid,
  output logic [$clog2(LANES):0]  out_count,
  output logic                    out_last,
  output logic [1:0]              out_ctrl,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int LOG = $clog2(LANES);
  localparam int S   = LOG * (LOG + 1) / 2;
  localparam int CW  = LOG + 1;
  localparam int MS  = (S > 1) ? S - 1 : 1;

  // Block size k of compare-exchange stage s in the standard bitonic schedule.
  function automatic int stage_k(input int s);
    int idx;
    int res;
    idx = 32'sd0;
    res = 32'sd2;
    for (int p = 32'sd1; p <= LOG; p++) begin
      for (int q = p; q >= 32'sd1; q--) begin
        if (idx == s) res = 32'sd1 <<< p;
        idx++;
      end
    end
    return res;
  endfunction

  function automatic int stage_j(input int s);
    int idx;
    int res;
    idx = 32'sd0;
    res = 32'sd1;
    for (int p = 32'sd1; p <= LOG; p++) begin
      for (int q = p; q >= 32'sd1; q--) begin
        if (idx == s) res = 32'sd1 <<< (q - 32'sd1);
        idx++;
      end
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [LANES-1:0] v);
    logic [CW-1:0] n;
    n = {CW{1'b0}};
    for (int i = 32'sd0; i < LANES; i++) begin
      n = n + {{(CW-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  logic [DATA_W-1:0] src_data_s [S][LANES];
  logic              src_lv_s   [S][LANES];
  logic              src_mode_s [S];
  logic [DATA_W-1:0] nxt_data_s [S][LANES];
  logic              nxt_lv_s   [S][LANES];

  logic [DATA_W-1:0] data_r  [S][LANES];
  logic              lv_r    [S][LANES];
  logic              mode_r  [MS];
  logic              last_r  [S];
  logic [1:0]        ctrl_r  [S];
  logic              bv_r    [S];
  logic [CW-1:0]     count_r [S];
  logic              adv_s;

  assign adv_s    = ~bv_r[S-1] | out_ready;
  assign in_ready = adv_s;

  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int K = stage_k(s);
    localparam int J = stage_j(s);

    if (s == 0) begin : g_head
      for (genvar i = 0; i < LANES; i++) begin : g_src
        assign src_data_s[0][i] = in_data[i*DATA_W +: DATA_W];
        assign src_lv_s[0][i]   = in_lane_valid[i];
      end
      assign src_mode_s[0] = in_mode;
    end else begin : g_body
      for (genvar i = 0; i < LANES; i++) begin : g_src
        assign src_data_s[s][i] = data_r[s-1][i];
        assign src_lv_s[s][i]   = lv_r[s-1][i];
      end
      assign src_mode_s[s] = mode_r[s-1];
    end

    // Invalid lanes get the top key bit so they always sink behind valid ones.
    for (genvar i = 0; i < LANES; i++) begin : g_ce
      if ((i & J) == 32'sd0) begin : g_pair
        localparam int L   = i + J;
        localparam bit ASC = ((i & K) == 32'sd0);
        logic [KEY_W:0] key_lo_s;
        logic [KEY_W:0] key_hi_s;
        logic           swap_s;

        assign key_lo_s = {~src_lv_s[s][i],
                           src_mode_s[s] ? src_data_s[s][i][KEY_W-1:0] : {KEY_W{1'b0}}};
        assign key_hi_s = {~src_lv_s[s][L],
                           src_mode_s[s] ? src_data_s[s][L][KEY_W-1:0] : {KEY_W{1'b0}}};

        if (ASC) begin : g_up
          assign swap_s = (key_lo_s > key_hi_s);
        end else begin : g_dn
          assign swap_s = (key_lo_s < key_hi_s);
        end

        assign nxt_data_s[s][i] = swap_s ? src_data_s[s][L] : src_data_s[s][i];
        assign nxt_data_s[s][L] = swap_s ? src_data_s[s][i] : src_data_s[s][L];
        assign nxt_lv_s[s][i]   = swap_s ? src_lv_s[s][L]   : src_lv_s[s][i];
        assign nxt_lv_s[s][L]   = swap_s ? src_lv_s[s][i]   : src_lv_s[s][L];
      end
    end
  end

  // Pipeline registers: all stages shift together on adv, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 32'sd0; s < S; s++) begin
        for (int i = 32'sd0; i < LANES; i++) begin
          data_r[s][i] <= {DATA_W{1'b0}};
          lv_r[s][i]   <= 1'b0;
        end
        last_r[s]  <= 1'b0;
        ctrl_r[s]  <= 2'b00;
        bv_r[s]    <= 1'b0;
        count_r[s] <= {CW{1'b0}};
      end
      for (int m = 32'sd0; m < MS; m++) begin
        mode_r[m] <= 1'b0;
      end
    end else if (adv_s) begin
      for (int s = 32'sd0; s < S; s++) begin
        for (int i = 32'sd0; i < LANES; i++) begin
          data_r[s][i] <= nxt_data_s[s][i];
          lv_r[s][i]   <= nxt_lv_s[s][i];
        end
      end
      last_r[0]  <= in_last;
      ctrl_r[0]  <= in_ctrl;
      bv_r[0]    <= in_valid;
      count_r[0] <= popcount(in_lane_valid);
      for (int s = 32'sd1; s < S; s++) begin
        last_r[s]  <= last_r[s-1];
        ctrl_r[s]  <= ctrl_r[s-1];
        bv_r[s]    <= bv_r[s-1];
        count_r[s] <= count_r[s-1];
      end
      mode_r[0] <= in_mode;
      for (int m = 32'sd1; m < MS; m++) begin
        mode_r[m] <= mode_r[m-1];
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_out
    assign out_data[i*DATA_W +: DATA_W] = data_r[S-1][i];
    assign out_lane_valid[i]            = lv_r[S-1][i];
  end

  assign out_count = count_r[S-1];
  assign out_last  = last_r[S-1];
  assign out_ctrl  = ctrl_r[S-1];
  assign out_valid = bv_r[S-1];

endmodule

// File: tb/tb_sort_net.sv
// Self-checking bench for sort_net: randomized beats checked against a
// sort-by-rule reference model (multiset, valid mask, key order, sideband).
module tb_sort_net;
  localparam int LANES  = 8;
  localparam int DATA_W = 32;
  localparam int KEY_W  = 8;
  localparam int S      = 6;
  localparam int CW     = 4;
  localparam int IW     = DATA_W + 1;
  localparam int SNAP_W = 1 + LANES*DATA_W + LANES + CW + 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [LANES*DATA_W-1:0] in_data;
  logic [LANES-1:0]        in_lane_valid;
  logic                    in_mode;
  logic                    in_last;
  logic [1:0]              in_ctrl;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic [LANES-1:0]        out_lane_valid;
  logic [CW-1:0]           out_count;
  logic                    out_last;
  logic [1:0]              out_ctrl;
  logic                    out_valid;
  logic                    out_ready;

  sort_net #(.LANES(LANES), .DATA_W(DATA_W), .KEY_W(KEY_W)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_lane_valid(in_lane_valid), .in_mode(in_mode),
    .in_last(in_last), .in_ctrl(in_ctrl), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_lane_valid(out_lane_valid), .out_count(out_count),
    .out_last(out_last), .out_ctrl(out_ctrl), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*DATA_W-1:0] data;
    logic [LANES-1:0]        lv;
    logic                    mode;
    logic                    last;
    logic [1:0]              ctrl;
  } beat_t;

  typedef struct packed {
    logic [LANES-1:0]       mask;
    logic [CW-1:0]          cnt;
    logic [LANES*IW-1:0]    sig;
    logic [LANES*KEY_W-1:0] keys;
    logic                   last;
    logic [1:0]             ctrl;
  } view_t;

  int errors = 0;
  int checks = 0;

  function automatic int pop(input logic [LANES-1:0] v);
    int n = 0;
    for (int i = 0; i < LANES; i++) n += int'(v[i]);
    return n;
  endfunction

  // Sorted list of {valid, payload} pairs: equal iff one beat is a permutation of the other.
  function automatic logic [LANES*IW-1:0] multiset(input logic [LANES*DATA_W-1:0] d,
                                                   input logic [LANES-1:0] v);
    logic [IW-1:0]       it [LANES];
    logic [IW-1:0]       t;
    logic [LANES*IW-1:0] r;
    for (int i = 0; i < LANES; i++) it[i] = {v[i], d[i*DATA_W +: DATA_W]};
    for (int a = 0; a < LANES; a++)
      for (int b = 0; b < LANES-1-a; b++)
        if (it[b] > it[b+1]) begin t = it[b]; it[b] = it[b+1]; it[b+1] = t; end
    for (int i = 0; i < LANES; i++) r[i*IW +: IW] = it[i];
    return r;
  endfunction

  function automatic view_t model(input beat_t b);
    view_t e;
    int n;
    logic [KEY_W-1:0] ks [$];
    n = pop(b.lv);
    e.mask = '0;
    for (int i = 0; i < n; i++) e.mask[i] = 1'b1;
    e.cnt  = CW'(n);
    e.sig  = multiset(b.data, b.lv);
    e.keys = '0;
    if (b.mode) begin
      for (int i = 0; i < LANES; i++)
        if (b.lv[i]) ks.push_back(b.data[i*DATA_W +: KEY_W]);
      ks.sort();
      foreach (ks[k]) e.keys[k*KEY_W +: KEY_W] = ks[k];
    end
    e.last = b.last;
    e.ctrl = b.ctrl;
    return e;
  endfunction

  function automatic view_t observe(input logic mode);
    view_t o;
    int k = 0;
    o.mask = out_lane_valid;
    o.cnt  = out_count;
    o.sig  = multiset(out_data, out_lane_valid);
    o.keys = '0;
    if (mode) begin
      for (int i = 0; i < LANES; i++)
        if (out_lane_valid[i]) begin
          o.keys[k*KEY_W +: KEY_W] = out_data[i*DATA_W +: KEY_W];
          k++;
        end
    end
    o.last = out_last;
    o.ctrl = out_ctrl;
    return o;
  endfunction

  function automatic logic [SNAP_W-1:0] snap();
    return {out_valid, out_data, out_lane_valid, out_count, out_last, out_ctrl};
  endfunction

  function automatic beat_t rand_beat(input logic mode, input logic [LANES-1:0] lv, input int keymax);
    beat_t b;
    logic [31:0] r;
    for (int i = 0; i < LANES; i++) begin
      r = $urandom();
      b.data[i*DATA_W +: DATA_W] = {r[31:KEY_W], KEY_W'($urandom_range(keymax, 0))};
    end
    b.lv   = lv;
    b.mode = mode;
    b.last = 1'($urandom());
    b.ctrl = 2'($urandom());
    return b;
  endfunction

  task automatic drive(input beat_t b, input logic v);
    in_data = b.data; in_lane_valid = b.lv; in_mode = b.mode;
    in_last = b.last; in_ctrl = b.ctrl; in_valid = v;
  endtask

  // Sends one beat into an empty pipe and collects it; lat counts clock edges to out_valid.
  task automatic run_single(input beat_t b, output view_t o, output int lat);
    out_ready = 1'b1;
    drive(b, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    o = observe(b.mode);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_count, out_lane_valid, out_last, out_ctrl} !== '0 || out_data !== '0
        || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: out_valid=%b out_count=%0d out_lane_valid=%b out_last=%b out_ctrl=%b in_ready=%b, required all 0 and in_ready=1",
               out_valid, out_count, out_lane_valid, out_last, out_ctrl, in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_compaction();
    beat_t b; view_t o, e; int lat;
    b = rand_beat(1'b0, 8'b1010_0101, 255);
    e = model(b);
    run_single(b, o, lat);
    checks++;
    if (lat !== S) begin
      errors++; $display("FAIL compaction_latency: got %0d cycles, required %0d", lat, S);
    end
    checks++;
    if (o.mask !== 8'b0000_1111 || o.cnt !== 4'd4) begin
      errors++; $display("FAIL compaction_mask: lane_valid=%b count=%0d, required 00001111 4", o.mask, o.cnt);
    end
    checks++;
    if (o !== e) begin
      errors++; $display("FAIL compaction_beat: got %h, required %h", o, e);
    end
  endtask

  task automatic test_sort_full();
    logic [7:0] keys [LANES] = '{8'd7, 8'd3, 8'd9, 8'd1, 8'd0, 8'd255, 8'd4, 8'd2};
    logic [LANES*KEY_W-1:0] want = {8'd255, 8'd9, 8'd7, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    beat_t b; view_t o, e; int lat;
    b = rand_beat(1'b1, 8'hFF, 255);
    for (int i = 0; i < LANES; i++) b.data[i*DATA_W +: KEY_W] = keys[i];
    e = model(b);
    run_single(b, o, lat);
    checks++;
    if (o.keys !== want || o.cnt !== 4'd8 || o.mask !== 8'hFF) begin
      errors++; $display("FAIL sort_full_keys: keys=%h count=%0d mask=%b, required %h 8 11111111", o.keys, o.cnt, o.mask, want);
    end
    checks++;
    if (o !== e) begin
      errors++; $display("FAIL sort_full_beat: got %h, required %h", o, e);
    end
  endtask

  task automatic test_sort_partial();
    logic [7:0] keys [LANES] = '{8'd5, 8'd1, 8'd8, 8'd6, 8'd2, 8'd200, 8'd0, 8'd3};
    logic [6*KEY_W-1:0] want = {8'd200, 8'd8, 8'd3, 8'd2, 8'd1, 8'd0};
    beat_t b; view_t o, e; int lat;
    b = rand_beat(1'b1, 8'b1111_0110, 255);
    for (int i = 0; i < LANES; i++) b.data[i*DATA_W +: KEY_W] = keys[i];
    e = model(b);
    run_single(b, o, lat);
    checks++;
    if (o.keys[6*KEY_W-1:0] !== want || o.mask !== 8'b0011_1111 || o.cnt !== 4'd6) begin
      errors++; $display("FAIL sort_partial_keys: keys=%h mask=%b count=%0d, required %h 00111111 6", o.keys, o.mask, o.cnt, want);
    end
    checks++;
    if (o !== e) begin
      errors++; $display("FAIL sort_partial_beat: got %h, required %h", o, e);
    end
  endtask

  task automatic test_empty();
    beat_t b; view_t o, e; int lat;
    b = rand_beat(1'b1, 8'h00, 255);
    e = model(b);
    run_single(b, o, lat);
    checks++;
    if (lat !== S || o.cnt !== 4'd0 || o.mask !== 8'h00) begin
      errors++; $display("FAIL empty_beat: latency=%0d count=%0d mask=%b, required %0d 0 00000000", lat, o.cnt, o.mask, S);
    end
    checks++;
    if (o !== e) begin
      errors++; $display("FAIL empty_model: got %h, required %h", o, e);
    end
  endtask

  task automatic test_back_to_back();
    beat_t beats [20];
    beat_t q [$];
    view_t e, o;
    logic [SNAP_W-1:0] held;
    logic stalled;
    int sent, got, cyc;
    for (int k = 0; k < 20; k++) begin
      beats[k] = rand_beat(1'($urandom()), LANES'($urandom()), 15);
      beats[k].last = (k % 5 == 4);
      beats[k].ctrl = 2'(k % 4);
    end
    sent = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
    out_ready = 1'b1;
    drive(beats[0], 1'b1);
    while (got < 20 && cyc < 400) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (snap() !== held) begin
          errors++; $display("FAIL b2b_stall_stable: got %h, required %h", snap(), held);
        end
      end
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++; $display("FAIL b2b_in_ready: got %b, required %b", in_ready, (!out_valid || out_ready));
      end
      stalled = out_valid && !out_ready;
      held = snap();
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_beat: got a beat, required none pending");
        end else begin
          e = model(q[0]);
          o = observe(q[0].mode);
          void'(q.pop_front());
          if (o !== e) begin
            errors++; $display("FAIL b2b_beat%0d: got %h, required %h", got, o, e);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(beats[sent]);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      if (sent < 20) drive(beats[sent], 1'b1);
      else in_valid = 1'b0;
    end
    out_ready = 1'b1;
    checks++;
    if (got != 20 || q.size() != 0) begin
      errors++; $display("FAIL b2b_delivery: delivered %0d pending %0d, required 20 0", got, q.size());
    end
  endtask

  task automatic test_mode_alternate();
    beat_t beats [6];
    beat_t q [$];
    view_t e, o;
    int sent, got, cyc, first, last_cyc;
    for (int k = 0; k < 6; k++) beats[k] = rand_beat(1'(k % 2), LANES'($urandom()), 255);
    sent = 0; got = 0; cyc = 0; first = -1; last_cyc = -1;
    out_ready = 1'b1;
    while (got < 6 && cyc < 40) begin
      if (sent < 6) drive(beats[sent], 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      if (out_valid) begin
        if (got == 0) first = cyc;
        last_cyc = cyc;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL mode_alt_extra: got a beat, required none pending");
        end else begin
          e = model(q[0]);
          o = observe(q[0].mode);
          if (o !== e) begin
            errors++; $display("FAIL mode_alt_beat%0d (mode %0d): got %h, required %h", got, q[0].mode, o, e);
          end
          void'(q.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(beats[sent]);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (first != S || last_cyc != S + 5 || got != 6) begin
      errors++; $display("FAIL mode_alt_timing: first=%0d last=%0d delivered=%0d, required %0d %0d 6", first, last_cyc, got, S, S + 5);
    end
  endtask

  task automatic test_reset_midflight();
    beat_t b; view_t o, e; int lat;
    logic seen;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(rand_beat(1'b1, 8'hFF, 255), 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_lane_valid !== '0 || out_count !== '0) begin
      errors++; $display("FAIL midflight_reset: out_valid=%b in_ready=%b lane_valid=%b count=%0d, required 0 1 0 0",
                         out_valid, in_ready, out_lane_valid, out_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midflight_stale: out_valid seen=%b, required 0", seen);
    end
    b = rand_beat(1'b1, LANES'($urandom()), 255);
    e = model(b);
    run_single(b, o, lat);
    checks++;
    if (lat !== S) begin
      errors++; $display("FAIL midflight_latency: got %0d cycles, required %0d", lat, S);
    end
    checks++;
    if (o !== e) begin
      errors++; $display("FAIL midflight_beat: got %h, required %h", o, e);
    end
  endtask

  initial begin
    rst = 1'b0;
    in_data = '0; in_lane_valid = '0; in_mode = 1'b0; in_last = 1'b0;
    in_ctrl = 2'b00; in_valid = 1'b0; out_ready = 1'b1;
    test_reset();
    test_compaction();
    test_sort_full();
    test_sort_partial();
    test_empty();
    test_back_to_back();
    test_mode_alternate();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
